// File: rtl/calc_port_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | calc_port_checker: passive response checker for one calc1 port. It       |
// | snoops request beats, queues expected results, and scores DUV responses. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module calc_port_checker #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64,
   parameter int CNTW    = 16
) (
   input  logic            c_clk,
   input  logic            reset,
   input  logic [0:3]      req_cmd_in,
   input  logic [0:31]     req_data_in,
   input  logic [0:1]      out_resp,
   input  logic [0:31]     out_data,
   output logic            err_valid,
   output logic [0:2]      err_code,
   output logic [0:1]      exp_resp,
   output logic [0:31]     exp_data,
   output logic [0:CNTW-1] pass_count,
   output logic [0:CNTW-1] fail_count,
   output logic            busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OP2  = 1'b1;

   localparam logic [2:0] E_NONE  = 3'd0;
   localparam logic [2:0] E_RESP  = 3'd1;
   localparam logic [2:0] E_DATA  = 3'd2;
   localparam logic [2:0] E_SPUR  = 3'd3;
   localparam logic [2:0] E_TMO   = 3'd4;
   localparam logic [2:0] E_PROTO = 3'd5;
   localparam logic [2:0] E_OVFL  = 3'd6;

   localparam logic [WW-1:0]   TMO_LAST = WW'(TIMEOUT - 1);
   localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

   // Entry layout: {resp[1:0], data[31:0]}
   function automatic logic [33:0] calc_expect(input logic [3:0]  cmd,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      case (cmd)
         4'd1:    calc_expect = sum[32] ? {2'd2, 32'd0} : {2'd1, sum[31:0]};
         4'd2:    calc_expect = (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
         4'd5:    calc_expect = {2'd1, a << b[4:0]};
         4'd6:    calc_expect = {2'd1, a >> b[4:0]};
         default: calc_expect = {2'd2, 32'd0};
      endcase
   endfunction

   logic [3:0]      cmd_in;
   logic [31:0]     data_in;
   logic [1:0]      resp_in;
   logic [31:0]     rdata_in;

   logic [0:0]      state_q, state_d;
   logic [3:0]      cmd_q, cmd_d;
   logic [31:0]     op1_q, op1_d;
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic [CNTW-1:0] pass_q, pass_d;
   logic [CNTW-1:0] fail_q, fail_d;
   logic            err_valid_q, err_valid_d;
   logic [2:0]      err_code_q, err_code_d;
   logic [33:0]     mem_q [DEPTH];

   logic            push, proto_err;
   logic            empty, full;
   logic [33:0]     head, push_entry;
   logic            resp_seen, spurious, resp_pop, resp_bad, data_bad, resp_ok;
   logic            timeout, pop, overflow, do_write;

   assign cmd_in   = req_cmd_in;
   assign data_in  = req_data_in;
   assign resp_in  = out_resp;
   assign rdata_in = out_data;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      op1_d     = op1_q;
      push      = 1'b0;
      proto_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_in != 4'd0) begin
               state_d = ST_OP2;
               cmd_d   = cmd_in;
               op1_d   = data_in;
            end
         end
         default: begin
            // A command on the operand-2 beat aborts the request outright.
            state_d = ST_IDLE;
            if (cmd_in != 4'd0) begin
               proto_err = 1'b1;
            end else begin
               push = 1'b1;
            end
         end
      endcase
   end

   assign push_entry = calc_expect(cmd_q, op1_q, data_in);

   assign resp_seen = (resp_in != 2'd0);
   assign spurious  = resp_seen && empty;
   assign resp_pop  = resp_seen && !empty;
   assign resp_bad  = resp_pop && (resp_in != head[33:32]);
   assign data_bad  = resp_pop && !resp_bad && (rdata_in != head[31:0]);
   assign resp_ok   = resp_pop && !resp_bad && !data_bad;
   assign timeout   = !empty && !resp_seen && (wait_q == TMO_LAST);
   assign pop       = resp_pop || timeout;
   assign overflow  = push && full && !pop;
   assign do_write  = push && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_write};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
      wait_d   = (pop || empty) ? '0 : wait_q + 1'b1;

      if (resp_bad)       err_code_d = E_RESP;
      else if (data_bad)  err_code_d = E_DATA;
      else if (spurious)  err_code_d = E_SPUR;
      else if (timeout)   err_code_d = E_TMO;
      else if (proto_err) err_code_d = E_PROTO;
      else if (overflow)  err_code_d = E_OVFL;
      else                err_code_d = E_NONE;
      err_valid_d = (err_code_d != E_NONE);

      pass_d = pass_q;
      if (resp_ok && (pass_q != CNT_MAX)) begin
         pass_d = pass_q + 1'b1;
      end
      fail_d = fail_q;
      if (err_valid_d && (fail_q != CNT_MAX)) begin
         fail_d = fail_q + 1'b1;
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cmd_q       <= 4'd0;
         op1_q       <= 32'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         wait_q      <= '0;
         pass_q      <= '0;
         fail_q      <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= E_NONE;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         op1_q       <= op1_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         wait_q      <= wait_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the queue is empty.
   always_ff @(posedge c_clk) begin
      if (do_write) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
      end
   end

   assign err_valid  = err_valid_q;
   assign err_code   = err_code_q;
   assign exp_resp   = empty ? 2'd0  : head[33:32];
   assign exp_data   = empty ? 32'd0 : head[31:0];
   assign pass_count = pass_q;
   assign fail_count = fail_q;
   assign busy       = !empty || (state_q == ST_OP2);

endmodule
`default_nettype wire

// File: tb/tb_calc_port_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_calc_port_checker: directed and randomized checks of calc_port_checker|
// | against a queue-based reference model. Revision: 1.0                     |
// +--------------------------------------------------------------------------+
module tb_calc_port_checker;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
   localparam int CNTW    = 16;
   localparam int CNTW_S  = 3;

   typedef struct {
      logic [1:0]  r;
      logic [31:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_cmd  = 4'd0;
   logic [31:0] req_data = 32'd0;
   logic [1:0]  out_resp = 2'd0;
   logic [31:0] out_data = 32'd0;

   logic              err_valid, err_valid_s;
   logic [2:0]        err_code, err_code_s;
   logic [1:0]        exp_resp, exp_resp_s;
   logic [31:0]       exp_data, exp_data_s;
   logic [CNTW-1:0]   pass_count, fail_count;
   logic [CNTW_S-1:0] pass_count_s, fail_count_s;
   logic              busy, busy_s;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   calc_port_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) u_dut (
      .c_clk(clk), .reset(rst_n), .req_cmd_in(req_cmd), .req_data_in(req_data),
      .out_resp(out_resp), .out_data(out_data), .err_valid(err_valid),
      .err_code(err_code), .exp_resp(exp_resp), .exp_data(exp_data),
      .pass_count(pass_count), .fail_count(fail_count), .busy(busy)
   );

   calc_port_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNTW(CNTW_S)) u_dut_s (
      .c_clk(clk), .reset(rst_n), .req_cmd_in(req_cmd), .req_data_in(req_data),
      .out_resp(out_resp), .out_data(out_data), .err_valid(err_valid_s),
      .err_code(err_code_s), .exp_resp(exp_resp_s), .exp_data(exp_data_s),
      .pass_count(pass_count_s), .fail_count(fail_count_s), .busy(busy_s)
   );

   // ---------------- reference model ----------------
   ent_t        mq[$];
   int          m_pass = 0, m_fail = 0, m_code = 0;
   bit          m_pend = 1'b0;
   logic [3:0]  m_cmd  = 4'd0;
   logic [31:0] m_op1  = 32'd0;
   longint      cyc = 0, head_since = 0;

   function automatic ent_t model_expect(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
      ent_t e;
      logic [63:0] s;
      e.r = 2'd2;
      e.d = 32'd0;
      s = {32'd0, a} + {32'd0, b};
      case (c)
         4'd1: if (s[63:32] == 32'd0) begin e.r = 2'd1; e.d = s[31:0]; end
         4'd2: if (a >= b) begin e.r = 2'd1; e.d = a - b; end
         4'd5: begin e.r = 2'd1; e.d = a << b[4:0]; end
         4'd6: begin e.r = 2'd1; e.d = a >> b[4:0]; end
         default: ;
      endcase
      return e;
   endfunction

   // Lowest numeric code wins, so priority reduces to a minimum.
   function automatic int lower(input int cur, input int c);
      return (cur == 0 || c < cur) ? c : cur;
   endfunction

   function automatic longint sat(input int v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (longint'(v) > mx) ? mx : longint'(v);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_pass = 0; m_fail = 0; m_code = 0; m_pend = 1'b0;
         cyc = 0; head_since = 0;
      end else begin
         int   code;
         bit   popped;
         ent_t h;
         code   = 0;
         popped = 1'b0;
         cyc++;
         if (out_resp != 2'd0) begin
            if (mq.size() == 0) code = lower(code, 3);
            else begin
               h = mq.pop_front();
               popped = 1'b1;
               if (h.r != out_resp) code = lower(code, 1);
               else if (h.d != out_data) code = lower(code, 2);
               else m_pass++;
            end
         end else if (mq.size() != 0 && (cyc - head_since) == TIMEOUT) begin
            void'(mq.pop_front());
            popped = 1'b1;
            code = lower(code, 4);
         end
         if (popped) head_since = cyc;
         if (m_pend) begin
            m_pend = 1'b0;
            if (req_cmd != 4'd0) code = lower(code, 5);
            else if (mq.size() == DEPTH) code = lower(code, 6);
            else begin
               if (mq.size() == 0) head_since = cyc;
               mq.push_back(model_expect(m_cmd, m_op1, req_data));
            end
         end else if (req_cmd != 4'd0) begin
            m_pend = 1'b1;
            m_cmd  = req_cmd;
            m_op1  = req_data;
         end
         m_code = code;
         if (code != 0) m_fail++;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [1:0]  er;
         logic [31:0] ed;
         er = (mq.size() != 0) ? mq[0].r : 2'd0;
         ed = (mq.size() != 0) ? mq[0].d : 32'd0;
         check("err_valid", {63'd0, err_valid}, {63'd0, m_code != 0});
         check("err_code", 64'(err_code), 64'(m_code));
         check("exp_resp", 64'(exp_resp), 64'(er));
         check("exp_data", 64'(exp_data), 64'(ed));
         check("busy", {63'd0, busy}, {63'd0, (mq.size() != 0) || m_pend});
         check("pass_count", 64'(pass_count), 64'(sat(m_pass, CNTW)));
         check("fail_count", 64'(fail_count), 64'(sat(m_fail, CNTW)));
         check("pass_count_sat", 64'(pass_count_s), 64'(sat(m_pass, CNTW_S)));
         check("fail_count_sat", 64'(fail_count_s), 64'(sat(m_fail, CNTW_S)));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      req_cmd = c; req_data = a;
      tick();
      req_cmd = 4'd0; req_data = b;
      tick();
      req_data = 32'd0;
   endtask

   task automatic drive_resp(input logic [1:0] r, input logic [31:0] d);
      out_resp = r; out_data = d;
      tick();
      out_resp = 2'd0; out_data = 32'd0;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 40));
         1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [3:0] rand_cmd();
      case ($urandom_range(0, 4))
         0: return 4'd1;
         1: return 4'd2;
         2: return 4'd5;
         3: return 4'd6;
         default: return 4'($urandom_range(1, 15));
      endcase
   endfunction

   initial begin
      bit in_op2;
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_err_valid", {63'd0, err_valid}, 64'd0);
      check("rst_exp_data", 64'(exp_data), 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      tick();

      // add with result delivered three cycles after the op2 edge
      drive_req(4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
      check("add_exp_resp", 64'(exp_resp), 64'd1);
      check("add_exp_data", 64'(exp_data), 64'h2000_0000);
      tick(); tick();
      drive_resp(2'd1, 32'h2000_0000);
      check("add_pass", 64'(pass_count), 64'd1);
      check("add_no_err", {63'd0, err_valid}, 64'd0);
      check("add_busy_fall", {63'd0, busy}, 64'd0);

      // add carry-out, then a wrong resp code
      drive_req(4'd1, 32'hFFFF_FFFF, 32'h1);
      check("carry_exp_resp", 64'(exp_resp), 64'd2);
      check("carry_exp_data", 64'(exp_data), 64'd0);
      tick();
      drive_resp(2'd2, 32'd0);
      check("carry_pass", 64'(pass_count), 64'd2);
      drive_req(4'd1, 32'hFFFF_FFFF, 32'h1);
      tick();
      drive_resp(2'd1, 32'd0);
      check("resp_err_code", 64'(err_code), 64'd1);
      check("resp_err_fail", 64'(fail_count), 64'd1);

      // sub underflow passes, shift-right data mismatch
      drive_req(4'd2, 32'h1, 32'hF);
      tick();
      drive_resp(2'd2, 32'd0);
      check("sub_pass", 64'(pass_count), 64'd3);
      drive_req(4'd6, 32'h8000_0000, 32'h1);
      check("shr_exp_data", 64'(exp_data), 64'h4000_0000);
      tick();
      drive_resp(2'd1, 32'h8000_0000);
      check("data_err_code", 64'(err_code), 64'd2);

      // timeout exactly TIMEOUT cycles after the push edge
      drive_req(4'd6, 32'h1234_5678, 32'h4);
      for (int k = 1; k <= TIMEOUT; k++) begin
         tick();
         if (k == TIMEOUT - 1) check("tmo_not_early", {63'd0, err_valid}, 64'd0);
      end
      check("tmo_err_valid", {63'd0, err_valid}, 64'd1);
      check("tmo_err_code", 64'(err_code), 64'd4);
      check("tmo_queue_empty", {63'd0, busy}, 64'd0);
      drive_resp(2'd1, 32'd0);
      check("spur_err_code", 64'(err_code), 64'd3);

      // overflow on the fifth push, then a protocol error
      for (int i = 0; i < 5; i++) drive_req(4'd1, 32'(i), 32'd100);
      check("ovfl_err_code", 64'(err_code), 64'd6);
      check("ovfl_head", 64'(exp_data), 64'd100);
      req_cmd = 4'd1; req_data = 32'd7;
      tick();
      req_cmd = 4'd2; req_data = 32'd8;
      tick();
      req_cmd = 4'd0; req_data = 32'd0;
      check("proto_err_code", 64'(err_code), 64'd5);
      for (int i = 0; i < 4; i++) drive_resp(2'd1, 32'(i + 100));
      check("drain_pass", 64'(pass_count), 64'd7);
      check("drain_fail", 64'(fail_count), 64'd6);
      check("drain_empty", {63'd0, busy}, 64'd0);

      // reset with two entries pending
      drive_req(4'd1, 32'd2, 32'd3);
      drive_req(4'd5, 32'd1, 32'd4);
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_busy", {63'd0, busy}, 64'd0);
      check("rst_mid_exp_resp", 64'(exp_resp), 64'd0);
      check("rst_mid_exp_data", 64'(exp_data), 64'd0);
      check("rst_mid_pass", 64'(pass_count), 64'd0);
      check("rst_mid_fail", 64'(fail_count), 64'd0);
      check("rst_mid_err", {63'd0, err_valid}, 64'd0);
      rst_n = 1'b1;
      tick();
      drive_resp(2'd1, 32'd0);
      check("rst_spur_code", 64'(err_code), 64'd3);
      check("rst_spur_fail", 64'(fail_count), 64'd1);

      // randomized traffic, scored continuously by the compare process
      in_op2 = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         if (in_op2) begin
            req_cmd = ($urandom_range(0, 19) == 0) ? rand_cmd() : 4'd0;
            in_op2  = 1'b0;
         end else begin
            req_cmd = ($urandom_range(0, 2) == 0) ? rand_cmd() : 4'd0;
            in_op2  = (req_cmd != 4'd0);
         end
         req_data = rand_operand();
         if (mq.size() != 0 && $urandom_range(0, 3) == 0) begin
            out_resp = mq[0].r;
            out_data = mq[0].d;
            case ($urandom_range(0, 9))
               0: out_resp = 2'($urandom_range(1, 3));
               1: out_data = out_data ^ (32'd1 << $urandom_range(0, 31));
               default: ;
            endcase
         end else if ($urandom_range(0, 49) == 0) begin
            out_resp = 2'($urandom_range(1, 3));
            out_data = $urandom;
         end else begin
            out_resp = 2'd0;
            out_data = $urandom;
         end
         tick();
      end
      req_cmd = 4'd0; out_resp = 2'd0;
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/calc_port_checker.md
# calc_port_checker

Passive response checker for one calc1 port. It snoops the request side of the port (cmd plus two operand beats), computes the expected response, and queues it in order. It then compares each DUV response against the head of the queue and counts pass/fail. Four instances sit beside the DUV in the calc1 bench, one per port, as the receiving end of the request/response protocol the stimulus drives.

## Interface
- DEPTH, 4: expected-result queue entries (power of 2, ≥2)
- TIMEOUT, 64: max cycles the queue head may wait for a response
- CNTW, 16: width of pass/fail counters
- c_clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- req_cmd_in  in  [0:3]  snooped port command (bit 0 = MSB)
- req_data_in  in  [0:31]  snooped port data
- out_resp  in  [0:1]  snooped DUV response; 0 = none, 1 = success, 2 = overflow/underflow/invalid, 3 = internal error
- out_data  in  [0:31]  snooped DUV result
- err_valid  out  1  one-cycle pulse, error detected this cycle
- err_code  out  [0:2]  error cause, valid with err_valid
- exp_resp  out  [0:1]  expected resp of the current queue head
- exp_data  out  [0:31]  expected data of the current queue head
- pass_count  out  [0:CNTW-1]  responses matched, saturating
- fail_count  out  [0:CNTW-1]  error cycles, saturating
- busy  out  1  queue non-empty or operand 2 pending

## Operation
- Capture FSM has two states, IDLE and OP2.
  - IDLE: a non-zero req_cmd_in latches cmd and op1 = req_data_in, then goes to OP2.
  - OP2: latches op2 = req_data_in, computes the expected result, pushes it, returns to IDLE.
- Expected result:
  - cmd 1, add: 33-bit sum. Carry out gives resp 2 / data 0; otherwise resp 1 / sum.
  - cmd 2, sub: op2 > op1 (unsigned) gives resp 2 / data 0; otherwise resp 1 / op1-op2.
  - cmd 5, shift left: op1 << op2[27:31], resp 1.
  - cmd 6, shift right: op1 >> op2[27:31], logical, resp 1.
  - Any other non-zero cmd: resp 2 / data 0.
- Protocol error (err_code 5): req_cmd_in ≠ 0 during OP2. The request is dropped, nothing is pushed, and the FSM returns to IDLE. That cmd is not accepted as a new request.
- Queue overflow (err_code 6): push while the queue holds DEPTH entries. The new entry is dropped.
- Response check when out_resp ≠ 0:
  - Queue empty at start of cycle: spurious response (err_code 3).
  - Otherwise pop the head.
  - out_resp ≠ exp_resp gives err_code 1.
  - Else out_data ≠ exp_data gives err_code 2. Data is compared for both resp 1 and resp 2.
  - Else pass_count +1.
- Timeout:
  - The wait counter clears on every pop and whenever the queue is empty.
  - It increments each cycle the queue is non-empty.
  - At TIMEOUT the head is popped with err_code 4.
- One error is reported per cycle. Priority, highest first: 1, 2, 3, 4, 5, 6.
- fail_count increments once per cycle in which any error occurs. Lower-priority causes in that cycle are not separately reported.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values: err_valid 0, err_code 0, exp_resp 0, exp_data 0, pass_count 0, fail_count 0, busy 0. The FSM goes to IDLE, the queue empties, and the wait counter clears.
- Reset asserted mid-transaction discards any pending op1 and all queued entries.
- Push occurs at the rising edge that samples op2. The entry is visible on exp_* the following cycle if the queue was empty.
- A response in the same cycle as the push of its own request is treated as spurious. The DUV minimum latency is ≥1 cycle after op2.
- Simultaneous push and pop are both performed. Occupancy is unchanged, and an overflow check is not triggered when the queue is full.
- err_valid, err_code and the counters are registered, asserting one cycle after the offending sampled inputs.
- exp_resp and exp_data always show the current head; they are 0 when the queue is empty.
- The queue read and write pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

## Test plan
- Add 0x0000_0001 + 0x1FFF_FFFF, then DUV returns resp 1 / 0x2000_0000 three cycles later: pass_count = 1, no err_valid, busy falls.
- Add 0xFFFF_FFFF + 0x1: exp_resp 2, exp_data 0. DUV resp 2 / 0 passes. DUV resp 1 / 0 gives err_code 1, fail_count = 1.
- Sub 0x1 − 0xF returns resp 2 / 0 and passes. Then shift-right 0x8000_0000 by 1, DUV returns 0x8000_0000: err_code 2.
- Cmd 6 with no DUV response for 64 cycles gives err_code 4 exactly at cycle 64 after the push, and the queue is empty. A later resp 1 gives err_code 3.
- Five back-to-back cmd 1 requests with no responses: the fifth gives err_code 6, and four entries remain queued. Then cmd 1 followed by cmd 2 on the op2 beat gives err_code 5.
- Queue two requests, then pull reset low before the responses arrive: all outputs go to 0 immediately, and a later DUV response gives err_code 3.
